// File: rtl/psum_drain_pkg.sv
// Shared constants, FSM state type and the per-lane shift+saturate helper
// used by the psum drain.
package psum_drain_pkg;

  localparam int MAC_NUMBER     = 14;
  localparam int PE_NUMBER      = 64;
  localparam int PSUM_WIDTH     = 22;
  localparam int OUT_WIDTH      = 4;
  localparam int LANES_PER_BEAT = 16;
  localparam int SHIFT_W        = 5;

  localparam int LANES       = MAC_NUMBER * PE_NUMBER;
  localparam int BEATS       = LANES / LANES_PER_BEAT;
  localparam int BEAT_W      = $clog2(BEATS);
  localparam int BEAT_PSUM_W = LANES_PER_BEAT * PSUM_WIDTH;
  localparam int BEAT_OUT_W  = LANES_PER_BEAT * OUT_WIDTH;

  localparam logic [PSUM_WIDTH-1:0] SAT_MAX =
    {{(PSUM_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Unsigned right shift then clamp to the largest OUT_WIDTH code.
  function automatic logic [OUT_WIDTH-1:0] sat_shift(
    input logic [PSUM_WIDTH-1:0] psum,
    input logic [SHIFT_W-1:0]    shift
  );
    logic [PSUM_WIDTH-1:0] t;
    t = psum >> shift;
    return (t > SAT_MAX) ? {OUT_WIDTH{1'b1}} : t[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Beat stream from the psum drain to the activation write-back buffer.
interface psum_drain_if;
  import psum_drain_pkg::*;

  logic                  m_valid;
  logic                  m_ready;
  logic [BEAT_OUT_W-1:0] m_data;
  logic [BEAT_W-1:0]     m_addr;
  logic                  m_last;

  modport master (
    output m_valid, m_data, m_addr, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_addr, m_last,
    output m_ready
  );

endinterface

// File: rtl/psum_quant.sv
// Single-lane requantizer: unsigned shift followed by saturation.
module psum_quant
  import psum_drain_pkg::*;
(
  input  logic [PSUM_WIDTH-1:0] lane,
  input  logic [SHIFT_W-1:0]    shift,
  output logic [OUT_WIDTH-1:0]  q
);

  assign q = sat_shift(lane, shift);

endmodule

// File: rtl/psum_drain.sv
// Snapshots the accumulator psum vector on i_finish, requantizes it and streams
// it out in beats. Define PSUM_DRAIN_ZERO_SKIP_EN to skip all-zero beats.
module psum_drain
  import psum_drain_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_finish,
  input  logic [PSUM_WIDTH*LANES-1:0] i_cpsum,
  input  logic [SHIFT_W-1:0]          cfg_shift,
  psum_drain_if.master                m,
  output logic                        o_busy,
  output logic                        o_overrun
);

  state_t                      state_r, state_nx_s;
  logic [PSUM_WIDTH*LANES-1:0] snap_r;
  logic [SHIFT_W-1:0]          shift_r;
  logic [BEAT_W-1:0]           beat_cnt_r, beat_nx_s;
  logic [BEAT_W-1:0]           first_beat_s, next_beat_s;
  logic                        overrun_r, overrun_set_s, capture_s;
  logic                        stream_s, last_s, hs_s;
  logic [BEAT_PSUM_W-1:0]      beat_psum_s;
  logic [BEAT_OUT_W-1:0]       beat_q_s;

  assign stream_s = (state_r == STREAM);
  assign last_s   = (beat_cnt_r == BEAT_W'(BEATS-1));
  assign hs_s     = stream_s && m.m_ready;

`ifdef PSUM_DRAIN_ZERO_SKIP_EN
  logic [LANES*OUT_WIDTH-1:0] in_q_s;
  logic [BEATS-1:0]           zf_in_s, zflag_r;

  for (genvar g = 0; g < LANES; g++) begin : g_in_quant
    psum_quant u_quant (
      .lane  (i_cpsum[g*PSUM_WIDTH +: PSUM_WIDTH]),
      .shift (cfg_shift),
      .q     (in_q_s[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_zflag
    assign zf_in_s[b] = ~|in_q_s[b*BEAT_OUT_W +: BEAT_OUT_W];
  end

  // Lowest non-zero beat of the incoming tile; the final beat is the fallback.
  always_comb begin
    first_beat_s = BEAT_W'(BEATS-1);
    for (int i = BEATS-2; i >= 0; i--) begin
      first_beat_s = zf_in_s[i] ? first_beat_s : BEAT_W'(i);
    end
  end

  // Lowest non-zero beat above the current one, again falling back to the final beat.
  always_comb begin
    next_beat_s = BEAT_W'(BEATS-1);
    for (int i = BEATS-2; i >= 0; i--) begin
      next_beat_s = (!zflag_r[i] && (BEAT_W'(i) > beat_cnt_r)) ? BEAT_W'(i) : next_beat_s;
    end
  end

  // Zero flags are taken together with the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zflag_r <= {BEATS{1'b0}};
    end else if (capture_s) begin
      zflag_r <= zf_in_s;
    end
  end
`else
  assign first_beat_s = {BEAT_W{1'b0}};
  assign next_beat_s  = beat_cnt_r + BEAT_W'(1);
`endif

  // Next-state logic; a finish on the final-beat handshake chains the next tile.
  always_comb begin
    state_nx_s    = state_r;
    beat_nx_s     = beat_cnt_r;
    capture_s     = 1'b0;
    overrun_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_finish) begin
          capture_s  = 1'b1;
          state_nx_s = STREAM;
          beat_nx_s  = first_beat_s;
        end else begin
          beat_nx_s  = {BEAT_W{1'b0}};
        end
      end
      STREAM: begin
        if (hs_s && last_s) begin
          if (i_finish) begin
            capture_s  = 1'b1;
            beat_nx_s  = first_beat_s;
          end else begin
            state_nx_s = IDLE;
            beat_nx_s  = {BEAT_W{1'b0}};
          end
        end else begin
          if (hs_s) begin
            beat_nx_s = next_beat_s;
          end else begin
            beat_nx_s = beat_cnt_r;
          end
          overrun_set_s = i_finish;
        end
      end
      default: begin
        state_nx_s = IDLE;
        beat_nx_s  = {BEAT_W{1'b0}};
      end
    endcase
  end

  // Control state: FSM, beat pointer and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      beat_cnt_r <= {BEAT_W{1'b0}};
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      beat_cnt_r <= beat_nx_s;
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Tile snapshot and its shift amount, frozen until the next accepted finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r  <= {(PSUM_WIDTH*LANES){1'b0}};
      shift_r <= {SHIFT_W{1'b0}};
    end else if (capture_s) begin
      snap_r  <= i_cpsum;
      shift_r <= cfg_shift;
    end
  end

  assign beat_psum_s = snap_r[beat_cnt_r * BEAT_PSUM_W +: BEAT_PSUM_W];

  for (genvar j = 0; j < LANES_PER_BEAT; j++) begin : g_out_quant
    psum_quant u_quant (
      .lane  (beat_psum_s[j*PSUM_WIDTH +: PSUM_WIDTH]),
      .shift (shift_r),
      .q     (beat_q_s[j*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  assign m.m_valid = stream_s;
  assign m.m_addr  = beat_cnt_r;
  assign m.m_last  = stream_s && last_s;
  assign m.m_data  = stream_s ? beat_q_s : {BEAT_OUT_W{1'b0}};
  assign o_busy    = stream_s;
  assign o_overrun = overrun_r;

endmodule

// File: tb/tb_psum_drain.sv
// Randomized scoreboard bench for psum_drain: a reference model queues expected
// beats at each accepted finish and a negedge monitor checks every presented beat.
module tb_psum_drain;

  localparam int NL   = 896;
  localparam int NB   = 56;
  localparam int LPB  = 16;
  localparam int PW   = 22;
  localparam int OMAX = 15;

  typedef struct packed {
    logic [5:0]  addr;
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            fin;
  logic [PW*NL-1:0] cpsum;
  logic [4:0]      cfg;
  logic            o_busy;
  logic            o_overrun;

  psum_drain_if bus ();

  psum_drain dut (
    .clk       (clk),
    .rst       (rst),
    .i_finish  (fin),
    .i_cpsum   (cpsum),
    .cfg_shift (cfg),
    .m         (bus),
    .o_busy    (o_busy),
    .o_overrun (o_overrun)
  );

  exp_t        exp_q[$];
  logic [21:0] lanes [NL];
  int          total = 0;
  int          bad   = 0;
  bit          rand_ready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every presented beat must match the front of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.m_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got addr=%0d data=%h last=%0d, none expected",
                   bus.m_addr, bus.m_data, bus.m_last);
        end else begin
          e = exp_q[0];
          if (bus.m_addr !== e.addr || bus.m_data !== e.data || bus.m_last !== e.last) begin
            bad++;
            $display("FAIL beat got addr=%0d data=%h last=%0d expected addr=%0d data=%h last=%0d",
                     bus.m_addr, bus.m_data, bus.m_last, e.addr, e.data, e.last);
          end
          if (bus.m_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // Reference model: requantize every lane arithmetically and queue the beats.
  function automatic void model_push(input int sh);
    exp_t        e;
    int unsigned v;
    for (int b = 0; b < NB; b++) begin
      e.data = 64'd0;
      for (int j = 0; j < LPB; j++) begin
        v = int'(lanes[b*LPB+j]) >> sh;
        if (v > OMAX) v = OMAX;
        e.data[j*4 +: 4] = 4'(v);
      end
      e.addr = 6'(b);
      e.last = (b == NB-1);
`ifdef PSUM_DRAIN_ZERO_SKIP_EN
      if (e.data == 64'd0 && b != NB-1) continue;
`endif
      exp_q.push_back(e);
    end
  endfunction

  task automatic start_tile(input int sh, input bit push);
    for (int i = 0; i < NL; i++) cpsum[i*PW +: PW] = lanes[i];
    cfg = 5'(sh);
    fin = 1'b1;
    if (push) model_push(sh);
    @(posedge clk);
    #1;
    fin = 1'b0;
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while ((o_busy || exp_q.size() != 0) && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (cyc >= 2000) begin
      bad++;
      $display("FAIL drain_timeout busy=%0d pending=%0d expected idle", o_busy, exp_q.size());
    end
  endtask

  task automatic wait_addr(input int a);
    int n = 0;
    while (!(bus.m_valid && bus.m_addr == 6'(a)) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL wait_addr got addr=%0d expected addr=%0d", bus.m_addr, a);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},   bus.m_valid, 64'd0);
    check({tag, "_addr"},    bus.m_addr,  64'd0);
    check({tag, "_last"},    bus.m_last,  64'd0);
    check({tag, "_data"},    bus.m_data,  64'd0);
    check({tag, "_busy"},    o_busy,      64'd0);
    check({tag, "_overrun"}, o_overrun,   64'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NL; i++)
      lanes[i] = 22'($urandom) & 22'((32'd1 << $urandom_range(1, 22)) - 32'd1);
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    fin   = 1'b0;
    cpsum = '0;
    cfg   = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Ramp tile at full throughput.
    for (int i = 0; i < NL; i++) lanes[i] = 22'(i);
    start_tile(0, 1'b1);
    wait_drain(cyc);
    check("ramp_cycles", 64'(cyc), 64'd56);

    // Saturation and shift boundaries.
    for (int i = 0; i < NL; i++) lanes[i] = 22'h3FFFFF;
    start_tile(18, 1'b1);
    wait_drain(cyc);
    start_tile(22, 1'b1);
    wait_drain(cyc);
    for (int i = 0; i < NL; i++) lanes[i] = 22'(i);
    start_tile(2, 1'b1);
    wait_drain(cyc);

    // Random data and shifts under random backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      fill_random();
      start_tile($urandom_range(0, 24), 1'b1);
      wait_drain(cyc);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Sparse tile (only beats 3 and 10 non-zero) and an all-zero tile.
    for (int i = 0; i < NL; i++) lanes[i] = 22'd0;
    for (int j = 0; j < LPB; j++) begin
      lanes[3*LPB+j]  = 22'($urandom_range(1, 15));
      lanes[10*LPB+j] = 22'($urandom_range(1, 15));
    end
    start_tile(0, 1'b1);
    wait_drain(cyc);
    for (int i = 0; i < NL; i++) lanes[i] = 22'd0;
    start_tile(0, 1'b1);
    wait_drain(cyc);

    // Back-to-back tile on the final-beat handshake.
    for (int i = 0; i < NL; i++) lanes[i] = 22'(i);
    start_tile(0, 1'b1);
    wait_addr(55);
    fill_random();
    start_tile(3, 1'b1);
    check("b2b_busy", o_busy, 64'd1);
    check("b2b_overrun", o_overrun, 64'd0);
    wait_drain(cyc);
    check("b2b_overrun_end", o_overrun, 64'd0);

    // Dropped finish mid-stream.
    for (int i = 0; i < NL; i++) lanes[i] = 22'(i * 3);
    start_tile(1, 1'b1);
    wait_addr(20);
    fill_random();
    start_tile(0, 1'b0);
    check("overrun_set", o_overrun, 64'd1);
    wait_drain(cyc);
    check("overrun_sticky", o_overrun, 64'd1);

    // Asynchronous reset mid-stream, then a fresh tile.
    fill_random();
    start_tile(2, 1'b1);
    wait_addr(30);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NL; i++) lanes[i] = 22'(i);
    start_tile(0, 1'b1);
    check("post_rst_addr", bus.m_addr, 64'd0);
    wait_drain(cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
